// File: rtl/rx_pkg.sv
// Shared types and defaults for the UART RX flow controller.
package rx_pkg;

    localparam int unsigned DEF_DEPTH       = 16;
    localparam int unsigned DEF_HI_MARK     = 12;
    localparam int unsigned DEF_LO_MARK     = 4;
    localparam int unsigned DEF_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DROP  = 2'd2
    } wr_state_e;

    // Width of an occupancy counter able to hold 0..depth inclusive.
    function automatic int unsigned CNT_W(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/rx_flow_ctl_if.sv
// Host/FIFO/receiver-facing signal bundle of the RX flow controller.
interface rx_flow_ctl_if
    import rx_pkg::*;
#(
    parameter int unsigned DEPTH = DEF_DEPTH
);
    localparam int unsigned CW = CNT_W(DEPTH);

    logic          en;
    logic          rx_rdy;
    logic [7:0]    rx_data;
    logic          rd_req;
    logic          clr_ovr;
    logic          fifo_full;
    logic          fifo_empty;
    logic          fifo_wr;
    logic [7:0]    fifo_din;
    logic          fifo_rd;
    logic          dout_valid;
    logic          rts;
    logic          overrun;
    logic [CW-1:0] count;

    // Controller side.
    modport master (
        input  en, rx_rdy, rx_data, rd_req, clr_ovr, fifo_full, fifo_empty,
        output fifo_wr, fifo_din, fifo_rd, dout_valid, rts, overrun, count
    );

    // Environment side: receiver, host and FIFO.
    modport slave (
        output en, rx_rdy, rx_data, rd_req, clr_ovr, fifo_full, fifo_empty,
        input  fifo_wr, fifo_din, fifo_rd, dout_valid, rts, overrun, count
    );

endinterface

// File: rtl/rx_flow_ctl_sync_edge.sv
// Multi-flop synchronizer with a registered rising-edge pulse on the synchronized level.
module sync_edge #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] fill_q;
    logic              prev_q;

    // prev_q stays 1 until the chain holds real samples, so a level already
    // high at reset release is not mistaken for a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            prev_q <= 1'b1;
            pulse  <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
            fill_q <= {fill_q[STAGES-2:0], 1'b1};
            prev_q <= sync_q[STAGES-1] | ~fill_q[STAGES-1];
            pulse  <= sync_q[STAGES-1] & ~prev_q;
        end
    end

endmodule

// File: rtl/rx_flow_ctl.sv
// UART RX flow controller: byte capture and FIFO write sequencing, read gating,
// occupancy tracking with rts watermark hysteresis, and a sticky overrun flag.
module rx_flow_ctl
    import rx_pkg::*;
#(
    parameter int unsigned DEPTH       = DEF_DEPTH,
    parameter int unsigned HI_MARK     = DEF_HI_MARK,
    parameter int unsigned LO_MARK     = DEF_LO_MARK,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic          clk,
    input  logic          rst,
    rx_flow_ctl_if.master bus
);

    localparam int unsigned CW = CNT_W(DEPTH);

    wr_state_e     state_q;
    wr_state_e     state_d;
    logic          new_byte;
    logic          wr_c;
    logic          drop_c;
    logic          rd_c;
    logic [7:0]    hold_q;
    logic          dout_valid_q;
    logic          rts_q;
    logic          ovr_q;
    logic [CW-1:0] count_q;

    sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d     (bus.rx_rdy),
        .pulse (new_byte)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // new_byte pulses are at least two cycles apart, so only IDLE needs to see them.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (new_byte && bus.en) state_d = bus.fifo_full ? DROP : WRITE;
            end
            WRITE:   state_d = IDLE;
            DROP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_c   = 1'b0;
        drop_c = 1'b0;
        case (state_q)
            WRITE:   wr_c   = 1'b1;
            DROP:    drop_c = 1'b1;
            default: ;
        endcase
    end

    assign rd_c = bus.rd_req & ~bus.fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q       <= '0;
            dout_valid_q <= 1'b0;
            count_q      <= '0;
            rts_q        <= 1'b1;
            ovr_q        <= 1'b0;
        end else begin
            if (new_byte && bus.en) hold_q <= bus.rx_data;
            dout_valid_q <= rd_c;

            // Simultaneous write and read leave occupancy unchanged.
            case ({wr_c, rd_c})
                2'b10:   if (count_q != CW'(DEPTH)) count_q <= count_q + CW'(1);
                2'b01:   if (count_q != '0)         count_q <= count_q - CW'(1);
                default: ;
            endcase

            if (count_q >= CW'(HI_MARK))      rts_q <= 1'b0;
            else if (count_q <= CW'(LO_MARK)) rts_q <= 1'b1;

            if (drop_c)           ovr_q <= 1'b1;
            else if (bus.clr_ovr) ovr_q <= 1'b0;
        end
    end

    assign bus.fifo_wr    = wr_c;
    assign bus.fifo_din   = hold_q;
    assign bus.fifo_rd    = rd_c;
    assign bus.dout_valid = dout_valid_q;
    assign bus.rts        = rts_q & bus.en;
    assign bus.overrun    = ovr_q;
    assign bus.count      = count_q;

endmodule

// File: tb/tb_rx_flow_ctl.sv
// Self-checking bench for rx_flow_ctl: directed scenarios plus randomized traffic
// compared every cycle against a cycle-level behavioural model.
module tb_rx_flow_ctl;
    import rx_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned HI    = 12;
    localparam int unsigned LO    = 4;
    localparam int unsigned S     = 2;

    logic clk = 1'b0;
    logic rst;

    rx_flow_ctl_if #(.DEPTH(DEPTH)) bus ();

    rx_flow_ctl #(
        .DEPTH(DEPTH), .HI_MARK(HI), .LO_MARK(LO), .SYNC_STAGES(S)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: rx_rdy history gives the new-byte instants, the rest is
    // occupancy arithmetic and one-cycle scheduling of write/drop/valid events.
    int         m_count;
    bit         m_rts, m_ovr, pend_wr, in_drop, prev_rd;
    logic [7:0] pend_data;
    bit         h [0:7];
    bit         nb, e_rd;

    always @(negedge clk) begin
        if (rst) begin
            m_count = 0; m_rts = 1; m_ovr = 0;
            pend_wr = 0; in_drop = 0; prev_rd = 0;
            for (int i = 0; i < 8; i++) h[i] = bus.rx_rdy;
        end else begin
            for (int i = 7; i > 0; i--) h[i] = h[i-1];
            h[0] = bus.rx_rdy;
            // Level driven in cycle c is first sampled at edge c+1; the byte
            // strobe follows S edges later.
            nb   = h[S+1] && !h[S+2];
            e_rd = bus.rd_req && !bus.fifo_empty;

            check("fifo_wr", bus.fifo_wr, pend_wr);
            if (pend_wr) check("fifo_din", bus.fifo_din, pend_data);
            check("fifo_rd", bus.fifo_rd, e_rd);
            check("dout_valid", bus.dout_valid, prev_rd);
            check("count", bus.count, m_count);
            check("rts", bus.rts, m_rts && bus.en);
            check("overrun", bus.overrun, m_ovr);

            if (in_drop)          m_ovr = 1;
            else if (bus.clr_ovr) m_ovr = 0;
            if (m_count >= HI)      m_rts = 0;
            else if (m_count <= LO) m_rts = 1;
            if (pend_wr && !e_rd && m_count < DEPTH) m_count++;
            else if (!pend_wr && e_rd && m_count > 0) m_count--;
            pend_data = bus.rx_data;
            pend_wr   = nb && bus.en && !bus.fifo_full;
            in_drop   = nb && bus.en && bus.fifo_full;
            prev_rd   = e_rd;
        end
    end

    // One receiver byte; optionally pulse rd_req or clr_ovr in the write/drop cycle.
    task automatic send_byte(input logic [7:0] d, input bit rd_at, input bit clr_at);
        bus.rx_data = d;
        bus.rx_rdy  = 1'b1;
        step(); step(); step();
        bus.rx_rdy  = 1'b0;
        step();
        bus.rd_req  = rd_at;
        bus.clr_ovr = clr_at;
        step();
        bus.rd_req  = 1'b0;
        bus.clr_ovr = 1'b0;
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wr_seen;
        int hold_cnt;
        int rd_pct;

        rst = 1'b1;
        bus.en = 0; bus.rx_rdy = 0; bus.rx_data = 0; bus.rd_req = 0;
        bus.clr_ovr = 0; bus.fifo_full = 0; bus.fifo_empty = 1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        check("rst_count", bus.count, 0);
        check("rst_fifo_wr", bus.fifo_wr, 0);
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_overrun", bus.overrun, 0);
        check("rst_rts_en0", bus.rts, 0);
        step();
        bus.en = 1;
        @(negedge clk);
        check("rst_rts_en1", bus.rts, 1);

        // Single byte: write lands at N+3
        step();
        bus.rx_data = 8'hA5; bus.rx_rdy = 1;
        step(); step(); step();
        bus.rx_rdy = 0;
        @(negedge clk);
        check("lat_early_wr", bus.fifo_wr, 0);
        step();
        @(negedge clk);
        check("lat_wr", bus.fifo_wr, 1);
        check("lat_din", bus.fifo_din, 8'hA5);
        step(); step();
        @(negedge clk);
        check("single_count", bus.count, 1);
        check("single_ovr", bus.overrun, 0);

        // Overrun, clear, and set-wins-over-clear
        step();
        bus.fifo_full = 1;
        send_byte(8'h3C, 0, 0);
        @(negedge clk);
        check("ovr_set", bus.overrun, 1);
        check("ovr_count", bus.count, 1);
        step();
        bus.clr_ovr = 1; step(); bus.clr_ovr = 0;
        @(negedge clk);
        check("ovr_clr", bus.overrun, 0);
        step();
        send_byte(8'h5A, 0, 1);
        @(negedge clk);
        check("ovr_set_wins", bus.overrun, 1);
        step();
        bus.clr_ovr = 1; step(); bus.clr_ovr = 0;
        bus.fifo_full = 0;

        // Read while empty is ignored
        bus.fifo_empty = 1; bus.rd_req = 1;
        @(negedge clk);
        check("rd_empty_rd", bus.fifo_rd, 0);
        step();
        bus.rd_req = 0;
        @(negedge clk);
        check("rd_empty_dv", bus.dout_valid, 0);

        // Read with 3 bytes stored
        step();
        send_byte(8'h11, 0, 0);
        send_byte(8'h22, 0, 0);
        @(negedge clk);
        check("three_count", bus.count, 3);
        step();
        bus.fifo_empty = 0; bus.rd_req = 1;
        @(negedge clk);
        check("rd_same_cycle", bus.fifo_rd, 1);
        step();
        bus.rd_req = 0;
        @(negedge clk);
        check("rd_dout_valid", bus.dout_valid, 1);
        check("rd_count", bus.count, 2);

        // High watermark
        step();
        for (int i = 0; i < 9; i++) send_byte(8'(8'h80 + i), 0, 0);
        @(negedge clk);
        check("wm_count11", bus.count, 11);
        check("wm_rts11", bus.rts, 1);
        step();
        send_byte(8'hC0, 0, 0);
        @(negedge clk);
        check("wm_count12", bus.count, 12);
        check("wm_rts12", bus.rts, 0);

        // Low watermark: still low at 5, rises the cycle after 4
        step();
        bus.rd_req = 1;
        repeat (7) step();
        bus.rd_req = 0;
        @(negedge clk);
        check("wm_count5", bus.count, 5);
        check("wm_rts5", bus.rts, 0);
        step();
        bus.rd_req = 1; step(); bus.rd_req = 0;
        @(negedge clk);
        check("wm_count4", bus.count, 4);
        check("wm_rts4_lag", bus.rts, 0);
        step();
        @(negedge clk);
        check("wm_rts4", bus.rts, 1);

        // Simultaneous read and write at count 5
        step();
        send_byte(8'h33, 0, 0);
        @(negedge clk);
        check("rw_pre", bus.count, 5);
        step();
        send_byte(8'h44, 1, 0);
        @(negedge clk);
        check("rw_count", bus.count, 5);

        // Disabled receive: byte ignored even when full
        step();
        bus.en = 0; bus.fifo_full = 1;
        send_byte(8'h55, 0, 0);
        @(negedge clk);
        check("dis_count", bus.count, 5);
        check("dis_ovr", bus.overrun, 0);
        check("dis_rts", bus.rts, 0);
        step();
        bus.en = 1; bus.fifo_full = 0;

        // Async reset during WRITE with rx_rdy held high
        bus.rx_data = 8'h66; bus.rx_rdy = 1;
        step(); step(); step(); step();
        check("mid_wr_pre", bus.fifo_wr, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_wr", bus.fifo_wr, 0);
        check("mid_rst_count", bus.count, 0);
        check("mid_rst_dv", bus.dout_valid, 0);
        check("mid_rst_rts", bus.rts, 1);
        check("mid_rst_din", bus.fifo_din, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        wr_seen = 0;
        repeat (12) begin
            @(negedge clk);
            wr_seen += int'(bus.fifo_wr);
        end
        check("no_spurious_wr", wr_seen, 0);
        step();
        bus.rx_rdy = 0;
        repeat (3) step();
        send_byte(8'h77, 0, 0);
        @(negedge clk);
        check("post_rst_count", bus.count, 1);
        check("post_rst_din", bus.fifo_din, 8'h77);

        // Randomized traffic against the model
        step();
        hold_cnt = 1;
        for (int i = 0; i < 4000; i++) begin
            rd_pct = ((i / 500) % 2 == 1) ? 45 : 8;
            hold_cnt--;
            if (hold_cnt <= 0) begin
                bus.rx_rdy = ~bus.rx_rdy;
                if (!bus.rx_rdy) bus.rx_data = 8'($urandom);
                hold_cnt = int'($urandom_range(1, 4));
            end
            bus.rd_req  = ($urandom_range(0, 99) < rd_pct);
            bus.clr_ovr = ($urandom_range(0, 99) < 4);
            if ($urandom_range(0, 99) < 2) bus.en = ~bus.en;
            if ($urandom_range(0, 99) < 10) begin
                bus.fifo_full  = 1'($urandom);
                bus.fifo_empty = 1'($urandom);
            end else begin
                bus.fifo_full  = (m_count >= DEPTH);
                bus.fifo_empty = (m_count == 0);
            end
            step();
        end
        bus.rd_req = 0; bus.clr_ovr = 0; bus.rx_rdy = 0;
        repeat (6) step();
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
